burst_ram: RTL and testbench

//  Parametrised single-port synchronous RAM with a burst-command front end.
//  One command moves LEN+1 beats from a start address, auto-incrementing.

---
 rtl/burst_ram.sv | 196 +++++++++++++++++++
 tb/tb_burst_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram.sv
// burst_ram: single-port synchronous RAM behind a burst-command front end.
// A command moves cmd_len+1 beats from cmd_addr with auto-increment. Write
// beats arrive on a valid/ready stream; read beats leave through a 2-entry
// output buffer with valid/ready backpressure.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_we, cmd_addr, cmd_len       direction, start address, beats-1
//   wvalid/wready, wdata            write beat stream
//   rvalid/rready, rdata            read beat stream
//   busy                            burst in progress
//   done                            1-cycle pulse after the final beat
//   err                             1-cycle pulse on a rejected command
module burst_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned EXT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    iss_q, iss_d;     // beats still to write / issue
  logic [CNT_W-1:0]    pop_q, pop_d;     // read beats still to hand out
  logic [1:0]          cnt_q, cnt_d;     // output buffer occupancy
  logic [DATA_W-1:0]   rdata_q, rdata_d; // buffer head
  logic [DATA_W-1:0]   spare_q, spare_d; // buffer second entry
  logic                cmd_ready_q, cmd_ready_d;
  logic                wready_q, wready_d;
  logic                rvalid_q, rvalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cmd_fire, w_fire, r_pop, r_issue, overflow;
  logic [EXT_W-1:0]    end_addr;
  logic [DATA_W-1:0]   rd_word;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign w_fire   = wvalid && wready_q;
  assign r_pop    = rvalid_q && rready;
  assign r_issue  = (state_q == READ) && (iss_q != '0) && (cnt_q < 2'd2);

  // Last address of the burst, one bit wider so a top-crossing is visible.
  assign end_addr = EXT_W'(cmd_addr) + EXT_W'(cmd_len);
  assign overflow = !WRAP && (end_addr > EXT_W'(DEPTH - 1));

  assign rd_word = mem[addr_q];

  // Storage array: written on every accepted write beat, never reset.
  always_ff @(posedge clk) begin
    if (w_fire) mem[addr_q] <= wdata;
  end

  // Next-state, counters, output buffer and registered outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    pop_d   = pop_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    spare_d = spare_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d = cmd_addr;
          iss_d  = CNT_W'(cmd_len) + CNT_W'(1);
          pop_d  = CNT_W'(cmd_len) + CNT_W'(1);
          if (overflow) err_d   = 1'b1;
          else          state_d = cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        if (w_fire) begin
          addr_d = addr_q + ADDR_W'(1);
          iss_d  = iss_q - CNT_W'(1);
          if (iss_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (r_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          iss_d  = iss_q - CNT_W'(1);
        end
        if (r_pop) begin
          pop_d = pop_q - CNT_W'(1);
          if (pop_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Two-entry buffer: head drives rdata directly so it holds while stalled.
    case ({r_pop, r_issue})
      2'b01: begin
        if (cnt_q == 2'd0) rdata_d = rd_word;
        else               spare_d = rd_word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd2) rdata_d = spare_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          rdata_d = rd_word;
        end else begin
          rdata_d = spare_q;
          spare_d = rd_word;
        end
      end
      default: ;
    endcase

    cmd_ready_d = (state_d == IDLE);
    wready_d    = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    rvalid_d    = (cnt_d != 2'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      iss_q       <= '0;
      pop_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      spare_q     <= '0;
      cmd_ready_q <= 1'b1;
      wready_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_q       <= iss_d;
      pop_q       <= pop_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      spare_q     <= spare_d;
      cmd_ready_q <= cmd_ready_d;
      wready_q    <= wready_d;
      rvalid_q    <= rvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wready    = wready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: randomized bursts against an array model of memory, plus
// directed cases for wrap, rejection, latency, backpressure and reset.
module tb_burst_ram;

  logic       clk, rst_n;
  logic       cmd_valid, n_cmd_valid, cmd_we;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wvalid, rready;
  logic [7:0] wdata;

  logic       cmd_ready, wready, rvalid, busy, done, err;
  logic [7:0] rdata;
  logic       n_cmd_ready, n_wready, n_rvalid, n_busy, n_done, n_err;
  logic [7:0] n_rdata;

  logic [7:0] model [256];
  int checks = 0;
  int failures = 0;

  burst_ram #(.DATA_W(8), .ADDR_W(8), .LEN_W(4), .WRAP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .busy(busy), .done(done), .err(err)
  );

  burst_ram #(.DATA_W(8), .ADDR_W(8), .LEN_W(4), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wvalid(wvalid), .wready(n_wready), .wdata(wdata),
    .rvalid(n_rvalid), .rready(rready), .rdata(n_rdata),
    .busy(n_busy), .done(n_done), .err(n_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write burst; dbase[8] selects fixed data dbase[7:0]+beat. With hold set,
  // cmd_valid stays high carrying a len-0 read of ra after the write is taken.
  task automatic wr_burst(input logic [7:0] a, input logic [3:0] l, input bit gaps,
                          input logic [8:0] dbase, input bit hold,
                          input logic [7:0] ra, output int cycles);
    int sent = 0;
    cycles = 0;
    @(negedge clk);
    chk("wr_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    if (hold) begin cmd_we = 1'b0; cmd_addr = ra; cmd_len = 4'd0; end
    else cmd_valid = 1'b0;
    chk("wr_busy", busy, 1);
    while (sent <= int'(l) && cycles < 200) begin
      wvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata  = dbase[8] ? 8'(int'(dbase[7:0]) + sent) : 8'($urandom);
      if (hold) chk("hold_cmd_ready", cmd_ready, 0);
      if (wvalid && wready) begin
        model[8'(int'(a) + sent)] = wdata;
        sent++;
      end
      cycles++;
      @(negedge clk);
    end
    wvalid = 1'b0;
    if (cycles >= 200) chk("wr_timeout", 1, 0);
    chk("wr_done", done, 1);
    chk("wr_idle", busy, 0);
    chk("wr_wready_low", wready, 0);
    chk("wr_cmd_ready_back", cmd_ready, 1);
  endtask

  // Read burst; mode 0: rready high, 1: toggle 1010.., 2: random.
  task automatic rd_burst(input logic [7:0] a, input logic [3:0] l, input int mode);
    int got = 0;
    int cyc = 0;
    @(negedge clk);
    chk("rd_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_latency_low", rvalid, 0);
    chk("rd_busy", busy, 1);
    rready = 1'b0;
    while (got <= int'(l) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ~rready : 1'($urandom_range(0, 1));
      if (mode == 0) chk("rd_stream", rvalid, 1);
      if (rvalid) begin
        chk("rd_data", rdata, model[8'(int'(a) + got)]);
        if (rready) got++;
      end
    end
    if (cyc >= 200) chk("rd_timeout", 1, 0);
    @(negedge clk);
    rready = 1'b0;
    chk("rd_done", done, 1);
    chk("rd_idle", busy, 0);
    chk("rd_cmd_ready_back", cmd_ready, 1);
    chk("rd_rvalid_low", rvalid, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; n_cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0; wvalid = 1'b0; wdata = '0; rready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_n_err", n_err, 0);
    rst_n = 1'b1;

    // Fill the whole memory so every later read has a known model value.
    for (int b = 0; b < 16; b++) wr_burst(8'(b * 16), 4'hF, 1'b1, 9'h0, 1'b0, 8'h0, cyc);

    // Random mix of bursts.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr_burst(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 9'h0, 1'b0, 8'h0, cyc);
      else
        rd_burst(8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    // Sustained write of A0..A3 at 0x10, then readback.
    wr_burst(8'h10, 4'd3, 1'b0, 9'h1A0, 1'b0, 8'h0, cyc);
    chk("t1_beat_cycles", 32'(cyc), 4);
    @(negedge clk);
    chk("t1_done_once", done, 0);
    rd_burst(8'h10, 4'd3, 0);

    // Backpressure with rready toggling.
    rd_burst(8'h0C, 4'd7, 1);

    // Wrap across the top with WRAP=1.
    wr_burst(8'hFE, 4'd3, 1'b0, 9'h1C0, 1'b0, 8'h0, cyc);
    chk("wrap_model_00", model[0], 8'hC2);
    rd_burst(8'hFC, 4'd7, 0);

    // WRAP=0: legal write FE,FF then a top-crossing write that must be dropped.
    @(negedge clk);
    n_cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'hFE; cmd_len = 4'd1;
    @(negedge clk);
    n_cmd_valid = 1'b0; wvalid = 1'b1; wdata = 8'h5A;
    chk("nw_wready", n_wready, 1);
    @(negedge clk);
    wdata = 8'hA5;
    @(negedge clk);
    wvalid = 1'b0;
    chk("nw_done", n_done, 1);
    n_cmd_valid = 1'b1; cmd_len = 4'd3;
    wvalid = 1'b1; wdata = 8'h11;
    @(negedge clk);
    n_cmd_valid = 1'b0;
    chk("nw_err", n_err, 1);
    chk("nw_busy", n_busy, 0);
    chk("nw_cmd_ready", n_cmd_ready, 1);
    chk("nw_wready_low", n_wready, 0);
    repeat (3) @(negedge clk);
    chk("nw_err_pulse", n_err, 0);
    wvalid = 1'b0;
    n_cmd_valid = 1'b1; cmd_we = 1'b0; cmd_len = 4'd1;
    @(negedge clk);
    n_cmd_valid = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("nw_rd0_valid", n_rvalid, 1);
    chk("nw_rd0", n_rdata, 8'h5A);
    @(negedge clk);
    chk("nw_rd1", n_rdata, 8'hA5);
    @(negedge clk);
    chk("nw_rd_done", n_done, 1);
    rready = 1'b0;

    // Single-beat read latency.
    rd_burst(8'h05, 4'd0, 0);

    // Reset in the middle of a read burst.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h30; cmd_len = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rvalid", rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_burst(8'h30, 4'd7, 2);

    // cmd_valid held through a write burst waits for IDLE.
    wr_burst(8'h40, 4'd2, 1'b0, 9'h0, 1'b1, 8'h10, cyc);
    @(negedge clk);
    cmd_valid = 1'b0; rready = 1'b1;
    chk("held_cmd_taken", busy, 1);
    @(negedge clk);
    chk("held_rvalid", rvalid, 1);
    chk("held_rdata", rdata, model[8'h10]);
    @(negedge clk);
    chk("held_done", done, 1);
    rready = 1'b0;

    // wvalid in IDLE must not touch memory.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wvalid = 1'b1; wdata = 8'($urandom);
      chk("idle_wready", wready, 0);
    end
    wvalid = 1'b0;

    // Full readback against the model.
    for (int b = 0; b < 16; b++) rd_burst(8'(b * 16), 4'hF, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
